// File: rtl/cartridge_loader_if.sv
// Wishbone write-only link between the cartridge loader (master) and the
// cartridge ROM's CROM slave port. Bit 0 of each vector is its MSB.
interface cartridge_loader_if;
  logic [0:20] wb_adr_o;
  logic [0:7]  wb_dat_o;
  logic        wb_we_o;
  logic [0:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_ack_i
  );
endinterface

// File: rtl/cartridge_loader.sv
// Cartridge loader: clears the cartridge control register, streams N bytes
// into the ROM array over wishbone, then writes the final control byte.
// Reports busy/done/error and a mod-256 checksum of accepted bytes.
module cartridge_loader #(
  parameter int unsigned CROM_SIZE = 17409,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [0:14] length,
  input  logic [0:7]  ctrl_val,
  input  logic [0:7]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [0:7]  checksum,
  cartridge_loader_if.master wb
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_FETCH = 3'd2,
    ST_WRITE = 3'd3,
    ST_CTRL  = 3'd4
  } state_t;

  // Last counter value before the strobe is declared dead.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [14:0] len_q, len_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [14:0] offset_q, offset_d;
  logic [7:0]  checksum_q, checksum_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        abort_pend_q, abort_pend_d;
  logic        error_q, error_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        s_ready_q, s_ready_d;
  logic        cyc_q, cyc_d;
  logic [20:0] adr_q, adr_d;
  logic [7:0]  dat_q, dat_d;

  logic len_legal;
  logic bus_ack;
  logic bus_tmo;
  logic abort_seen;
  logic last_byte;

  assign len_legal  = (length != 15'd0) && ({17'd0, length} <= CROM_SIZE);
  assign bus_ack    = cyc_q && wb.wb_ack_i;
  assign bus_tmo    = cyc_q && !wb.wb_ack_i && (tmo_q == TMO_LAST);
  // An abort raised during a bus cycle is remembered until that cycle ends.
  assign abort_seen = abort_pend_q || abort;
  assign last_byte  = ((offset_q + 15'd1) == len_q);

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      len_q        <= 15'd0;
      ctrl_q       <= 8'h00;
      offset_q     <= 15'd0;
      checksum_q   <= 8'h00;
      tmo_q        <= 8'd0;
      abort_pend_q <= 1'b0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      s_ready_q    <= 1'b0;
      cyc_q        <= 1'b0;
      adr_q        <= 21'd0;
      dat_q        <= 8'h00;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      ctrl_q       <= ctrl_d;
      offset_q     <= offset_d;
      checksum_q   <= checksum_d;
      tmo_q        <= tmo_d;
      abort_pend_q <= abort_pend_d;
      error_q      <= error_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      s_ready_q    <= s_ready_d;
      cyc_q        <= cyc_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
    end
  end

  // Next-state decode: sequencing of clear, byte fetch/write and control write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && len_legal) state_d = ST_CLR;
        else                    state_d = ST_IDLE;
      end
      ST_CLR: begin
        if (bus_tmo)      state_d = ST_IDLE;
        else if (bus_ack) state_d = abort_seen ? ST_IDLE : ST_FETCH;
        else              state_d = ST_CLR;
      end
      ST_FETCH: begin
        if (abort)        state_d = ST_IDLE;
        else if (s_valid) state_d = ST_WRITE;
        else              state_d = ST_FETCH;
      end
      ST_WRITE: begin
        if (bus_tmo) begin
          state_d = ST_IDLE;
        end else if (bus_ack) begin
          if (abort_seen)     state_d = ST_IDLE;
          else if (last_byte) state_d = ST_CTRL;
          else                state_d = ST_FETCH;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_CTRL: begin
        if (bus_tmo || bus_ack) state_d = ST_IDLE;
        else                    state_d = ST_CTRL;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered bus, stream and status outputs.
  always_comb begin
    len_d        = len_q;
    ctrl_d       = ctrl_q;
    offset_d     = offset_q;
    checksum_d   = checksum_q;
    error_d      = error_q;
    abort_pend_d = abort_pend_q;
    cyc_d        = cyc_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    done_d       = 1'b0;
    busy_d       = (state_d != ST_IDLE);
    s_ready_d    = (state_d == ST_FETCH);
    // Wait counter only runs while a strobe is unanswered.
    if (cyc_q && !wb.wb_ack_i) tmo_d = tmo_q + 8'd1;
    else                       tmo_d = 8'd0;

    case (state_q)
      ST_IDLE: begin
        abort_pend_d = 1'b0;
        if (start) begin
          len_d      = length;
          ctrl_d     = ctrl_val;
          checksum_d = 8'h00;
          offset_d   = 15'd0;
          error_d    = !len_legal;
          if (len_legal) begin
            // Control register cleared first so the CPU cannot touch the array.
            cyc_d = 1'b1;
            adr_d = 21'd0;
            dat_d = 8'h00;
          end else begin
            cyc_d = 1'b0;
          end
        end else begin
          cyc_d = 1'b0;
        end
      end
      ST_CLR, ST_CTRL: begin
        if (abort) abort_pend_d = 1'b1;
        else       abort_pend_d = abort_pend_q;
        if (bus_tmo || bus_ack) begin
          cyc_d  = 1'b0;
          done_d = (state_q == ST_CTRL) && bus_ack && !abort_seen;
          if (bus_tmo || abort_seen) error_d = 1'b1;
          else                       error_d = error_q;
        end else begin
          cyc_d = 1'b1;
        end
      end
      ST_FETCH: begin
        if (abort) begin
          // Byte on the stream is left unconsumed.
          error_d = 1'b1;
          cyc_d   = 1'b0;
        end else if (s_valid) begin
          checksum_d = checksum_q + s_data;
          cyc_d      = 1'b1;
          adr_d      = {1'b1, 5'b00000, offset_q};
          dat_d      = s_data;
        end else begin
          cyc_d = 1'b0;
        end
      end
      ST_WRITE: begin
        if (abort) abort_pend_d = 1'b1;
        else       abort_pend_d = abort_pend_q;
        if (bus_tmo) begin
          cyc_d   = 1'b0;
          error_d = 1'b1;
        end else if (bus_ack) begin
          // Offset stays within length-1: the last write does not advance it.
          if (last_byte) offset_d = offset_q;
          else           offset_d = offset_q + 15'd1;
          if (abort_seen) begin
            cyc_d   = 1'b0;
            error_d = 1'b1;
          end else if (last_byte) begin
            cyc_d = 1'b1;
            adr_d = 21'd0;
            dat_d = ctrl_q;
          end else begin
            cyc_d = 1'b0;
          end
        end else begin
          cyc_d = 1'b1;
        end
      end
      default: begin
        cyc_d = 1'b0;
      end
    endcase
  end

  assign s_ready      = s_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign checksum     = checksum_q;
  assign wb.wb_adr_o  = adr_q;
  assign wb.wb_dat_o  = dat_q;
  assign wb.wb_we_o   = cyc_q;
  assign wb.wb_sel_o  = cyc_q;
  assign wb.wb_stb_o  = cyc_q;
  assign wb.wb_cyc_o  = cyc_q;

endmodule

// File: tb/tb_cartridge_loader.sv
// Directed bench for cartridge_loader: a table of full loads plus hand
// sequences for timeout, abort and mid-cycle reset.
module tb_cartridge_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [0:14] length;
  logic [0:7]  ctrl_val;
  logic [0:7]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        busy;
  logic        done;
  logic        error;
  logic [0:7]  checksum;

  cartridge_loader_if wbi();

  cartridge_loader #(.CROM_SIZE(17409), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .length(length), .ctrl_val(ctrl_val), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .busy(busy), .done(done), .error(error),
    .checksum(checksum), .wb(wbi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model: acks one cycle after strobe, optionally late on one write.
  int   dly_idx  = -1;
  int   dly_len  = 0;
  bit   mute     = 1'b0;
  int   wait_cnt = 0;
  logic [20:0] log_adr[$];
  logic [7:0]  log_dat[$];

  always @(posedge clk) begin
    if (reset) begin
      wbi.wb_ack_i <= 1'b0;
      wait_cnt     <= 0;
    end else if (wbi.wb_ack_i) begin
      wbi.wb_ack_i <= 1'b0;
    end else if (wbi.wb_cyc_o && wbi.wb_stb_o && !mute) begin
      if (wait_cnt < ((log_adr.size() == dly_idx) ? dly_len : 0)) begin
        wait_cnt <= wait_cnt + 1;
      end else begin
        wbi.wb_ack_i <= 1'b1;
        wait_cnt     <= 0;
        log_adr.push_back(wbi.wb_adr_o);
        log_dat.push_back(wbi.wb_dat_o);
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  // Bus protocol monitor.
  int   done_cnt = 0;
  int   bad_done = 0;
  int   bad_cs   = 0;
  int   unstable = 0;
  logic stb_p = 1'b0;
  logic ack_p = 1'b0;
  logic [20:0] adr_p;
  logic [7:0]  dat_p;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      if (busy !== 1'b0) bad_done <= bad_done + 1;
    end
    if (wbi.wb_cyc_o !== wbi.wb_stb_o) bad_cs <= bad_cs + 1;
    if (wbi.wb_cyc_o === 1'b1 && (wbi.wb_we_o !== 1'b1 || wbi.wb_sel_o !== 1'b1))
      bad_cs <= bad_cs + 1;
    if (stb_p && wbi.wb_stb_o === 1'b1 && !ack_p &&
        (wbi.wb_adr_o !== adr_p || wbi.wb_dat_o !== dat_p))
      unstable <= unstable + 1;
    stb_p <= (wbi.wb_stb_o === 1'b1);
    ack_p <= (wbi.wb_ack_i === 1'b1);
    adr_p <= wbi.wb_adr_o;
    dat_p <= wbi.wb_dat_o;
  end

  logic [7:0] src[8];
  int         src_n;
  int         sent;

  task automatic do_start(input logic [14:0] len, input logic [7:0] cv);
    @(negedge clk);
    start    = 1'b1;
    length   = len;
    ctrl_val = cv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Feeds src[] on the stream until busy drops. ab_mode: 0 abort in FETCH,
  // 1 abort while an array write waits for ack, 2 abort together with ack.
  task automatic run_stream(input int budget, input int ab_after, input int ab_mode, output bit ok);
    bit pend    = 1'b0;
    bit aborted = 1'b0;
    ok      = 1'b0;
    sent    = 0;
    s_data  = src[0];
    s_valid = (src_n > 0);
    for (int c = 0; c < budget; c++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      if (!aborted && ab_after >= 0 && sent == ab_after) begin
        if ((ab_mode == 0 && s_ready) ||
            (ab_mode == 1 && wbi.wb_stb_o && wbi.wb_adr_o[0] && !wbi.wb_ack_i) ||
            (ab_mode == 2 && wbi.wb_ack_i && wbi.wb_adr_o[0])) begin
          abort   = 1'b1;
          aborted = 1'b1;
        end
      end
      pend = s_ready && s_valid && !abort;
      @(negedge clk);
      abort = 1'b0;
      if (pend) begin
        sent++;
        if (sent < src_n) s_data = src[sent];
        else              s_valid = 1'b0;
      end
    end
    s_valid = 1'b0;
    abort   = 1'b0;
  endtask

  task automatic check_log(input int nb, input bit with_ctrl, input logic [7:0] cv);
    int exp_n = 1 + nb + int'(with_ctrl);
    check("log_count", log_adr.size(), exp_n);
    if (log_adr.size() == exp_n) begin
      check("clr_adr", log_adr[0], 0);
      check("clr_dat", log_dat[0], 0);
      for (int k = 0; k < nb; k++) begin
        check($sformatf("arr_adr[%0d]", k), log_adr[k + 1], 32'h100000 + k);
        check($sformatf("arr_dat[%0d]", k), log_dat[k + 1], src[k]);
      end
      if (with_ctrl) begin
        check("ctrl_adr", log_adr[nb + 1], 0);
        check("ctrl_dat", log_dat[nb + 1], cv);
      end
    end
  endtask

  typedef struct {
    logic [14:0] len;
    logic [7:0]  ctrl;
    logic [31:0] bts;      // byte k in bits [8k+7:8k]
    int          dly_idx;  // slave write index that gets a late ack
    int          dly_len;
    logic        exp_err;
    logic [7:0]  exp_sum;
  } vec_t;

  vec_t vecs[6];
  bit   ok;
  int   cnt;
  int   d0;
  bit   found;

  initial begin
    vecs[0] = '{15'd3,     8'h23, 32'h00332211, -1, 0,  1'b0, 8'h66};
    vecs[1] = '{15'd0,     8'h55, 32'h00000000, -1, 0,  1'b1, 8'h00};
    vecs[2] = '{15'd17410, 8'h55, 32'h00000000, -1, 0,  1'b1, 8'h00};
    vecs[3] = '{15'd1,     8'h80, 32'h000000A5, -1, 0,  1'b0, 8'hA5};
    vecs[4] = '{15'd4,     8'h0F, 32'h808001FF, 2,  10, 1'b0, 8'h00};
    vecs[5] = '{15'd2,     8'h41, 32'h00002010, 3,  3,  1'b0, 8'h30};

    reset = 1'b1; start = 1'b0; abort = 1'b0; length = 15'd0;
    ctrl_val = 8'h00; s_data = 8'h00; s_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_sready", s_ready, 0);
    check("rst_checksum", checksum, 0);
    check("rst_cyc", wbi.wb_cyc_o, 0);
    check("rst_stb", wbi.wb_stb_o, 0);
    reset = 1'b0;
    @(negedge clk);

    // Table of complete loads and illegal lengths.
    for (int i = 0; i < 6; i++) begin
      log_adr.delete();
      log_dat.delete();
      d0      = done_cnt;
      dly_idx = vecs[i].dly_idx;
      dly_len = vecs[i].dly_len;
      for (int k = 0; k < 4; k++) src[k] = vecs[i].bts[8*k +: 8];
      src_n = vecs[i].exp_err ? 0 : int'(vecs[i].len);
      do_start(vecs[i].len, vecs[i].ctrl);
      if (vecs[i].exp_err) begin
        check($sformatf("v%0d_busy", i), busy, 0);
        check($sformatf("v%0d_cyc", i), wbi.wb_cyc_o, 0);
        repeat (3) @(negedge clk);
      end else begin
        run_stream(2000, -1, 0, ok);
        check($sformatf("v%0d_finished", i), ok, 1);
        check($sformatf("v%0d_done", i), done, 1);
        @(negedge clk);
        check_log(src_n, 1'b1, vecs[i].ctrl);
      end
      check($sformatf("v%0d_error", i), error, vecs[i].exp_err);
      check($sformatf("v%0d_checksum", i), checksum, vecs[i].exp_sum);
      check($sformatf("v%0d_done_count", i), done_cnt - d0, vecs[i].exp_err ? 0 : 1);
      if (vecs[i].exp_err) check($sformatf("v%0d_no_cycles", i), log_adr.size(), 0);
    end
    dly_idx = -1;

    // Silent slave during the clear write: strobe gives up after 255 cycles.
    log_adr.delete(); log_dat.delete();
    mute = 1'b1;
    d0   = done_cnt;
    do_start(15'd2, 8'h01);
    cnt = 0;
    for (int c = 0; c < 400; c++) begin
      if (!wbi.wb_stb_o) break;
      cnt++;
      @(negedge clk);
    end
    check("tmo_stb_cycles", cnt, 255);
    check("tmo_cyc", wbi.wb_cyc_o, 0);
    check("tmo_error", error, 1);
    check("tmo_busy", busy, 0);
    @(negedge clk);
    check("tmo_no_done", done_cnt - d0, 0);
    mute = 1'b0;

    // Abort in FETCH after two of five bytes; pending byte is not taken.
    log_adr.delete(); log_dat.delete();
    d0 = done_cnt;
    src[0] = 8'h01; src[1] = 8'h02; src[2] = 8'h03; src[3] = 8'h04; src[4] = 8'h05;
    src_n  = 5;
    do_start(15'd5, 8'h33);
    run_stream(500, 2, 0, ok);
    check("abf_finished", ok, 1);
    check("abf_error", error, 1);
    check("abf_checksum", checksum, 8'h03);
    @(negedge clk);
    check("abf_no_done", done_cnt - d0, 0);
    check_log(2, 1'b0, 8'h00);

    // Abort while the second array write waits for a late ack.
    log_adr.delete(); log_dat.delete();
    d0 = done_cnt;
    dly_idx = 2; dly_len = 5;
    src[0] = 8'h10; src[1] = 8'h20; src[2] = 8'h30; src[3] = 8'h40; src[4] = 8'h50;
    src_n  = 5;
    do_start(15'd5, 8'h33);
    run_stream(500, 2, 1, ok);
    check("abw_finished", ok, 1);
    check("abw_error", error, 1);
    check("abw_checksum", checksum, 8'h30);
    @(negedge clk);
    check("abw_no_done", done_cnt - d0, 0);
    check_log(2, 1'b0, 8'h00);
    dly_idx = -1;

    // Abort in the same cycle as the first array write's ack.
    log_adr.delete(); log_dat.delete();
    d0 = done_cnt;
    src[0] = 8'h77; src[1] = 8'h88;
    src_n  = 2;
    do_start(15'd2, 8'h12);
    run_stream(500, 1, 2, ok);
    check("aba_finished", ok, 1);
    check("aba_error", error, 1);
    check("aba_checksum", checksum, 8'h77);
    @(negedge clk);
    check("aba_no_done", done_cnt - d0, 0);
    check_log(1, 1'b0, 8'h00);

    // Largest legal length is accepted; aborted at the first fetch.
    log_adr.delete(); log_dat.delete();
    src[0] = 8'hEE;
    src_n  = 1;
    do_start(15'd17409, 8'h01);
    check("max_busy", busy, 1);
    check("max_error_cleared", error, 0);
    run_stream(500, 0, 0, ok);
    check("max_finished", ok, 1);
    check("max_error", error, 1);
    check("max_checksum", checksum, 8'h00);
    check_log(0, 1'b0, 8'h00);

    // Reset while an array write strobe is waiting for ack.
    log_adr.delete(); log_dat.delete();
    dly_idx = 1; dly_len = 20;
    do_start(15'd3, 8'h07);
    s_valid = 1'b1;
    s_data  = 8'h5A;
    found   = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (wbi.wb_stb_o && wbi.wb_adr_o[0]) begin
        found = 1'b1;
        break;
      end
    end
    check("rsw_reached_write", found, 1);
    s_valid = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    check("rsw_cyc", wbi.wb_cyc_o, 0);
    check("rsw_stb", wbi.wb_stb_o, 0);
    check("rsw_busy", busy, 0);
    check("rsw_sready", s_ready, 0);
    check("rsw_checksum", checksum, 0);
    reset   = 1'b0;
    dly_idx = -1;
    @(negedge clk);
    log_adr.delete(); log_dat.delete();
    d0 = done_cnt;
    src[0] = 8'h5A; src[1] = 8'hA5; src[2] = 8'h3C;
    src_n  = 3;
    do_start(15'd3, 8'h07);
    run_stream(500, -1, 0, ok);
    check("rsl_finished", ok, 1);
    check("rsl_done", done, 1);
    check("rsl_checksum", checksum, 8'h3B);
    check("rsl_error", error, 0);
    @(negedge clk);
    check("rsl_done_count", done_cnt - d0, 1);
    check_log(3, 1'b1, 8'h07);

    @(negedge clk);
    check("mon_done_with_busy", bad_done, 0);
    check("mon_cyc_stb_we_sel", bad_cs, 0);
    check("mon_adr_dat_stable", unstable, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

endmodule

// File: doc/cartridge_loader.md
# cartridge_loader

Wishbone master that fills the cartridge ROM array from a byte stream and then programs the cartridge control register (banked/mm/mbx/bank). It sits between the host-side image source (SD/SPI/serial front end, valid/ready byte stream) and the cartridge ROM's CROM wishbone slave port. It sequences a full load: disable cartridge modes, write N bytes from offset 0, write the final control byte. It reports done, error and a running checksum.

## Interface
- `CROM_SIZE`, 17409, number of array bytes; legal `length` is 1..CROM_SIZE
- `TIMEOUT`, 255, max cycles a wishbone strobe may wait for ack (8-bit counter)

- `clk`  in  1  system clock
- `reset`  in  1  reset; one clock, synchronous, active-high
- `start`  in  1  one-cycle load request; ignored while `busy`
- `abort`  in  1  cancel running load
- `length`  in  [0:14]  byte count, sampled on accepted `start`
- `ctrl_val`  in  [0:7]  final control byte, sampled on accepted `start`
- `s_data`  in  [0:7]  stream byte
- `s_valid`  in  1  stream byte valid
- `s_ready`  out  1  loader accepts byte this cycle
- `busy`  out  1  load in progress
- `done`  out  1  one-cycle pulse on successful completion
- `error`  out  1  sticky fault flag; cleared by next accepted `start`
- `checksum`  out  [0:7]  mod-256 sum of accepted bytes
- `wb_adr_o`  out  [0:20]  bit 0 = 1 array, 0 control; [6:20] array offset; [1:5] = 0
- `wb_dat_o`  out  [0:7]  write data
- `wb_we_o`  out  1  always 1 during cycles
- `wb_sel_o`  out  [0:0]  = 1 during cycles
- `wb_stb_o`, `wb_cyc_o`  out  1  strobe/cycle, always equal
- `wb_ack_i`  in  1  slave ack

## Operation
- States: IDLE, CLR, FETCH, WRITE, CTRL.
- IDLE: on `start`, latch `length` and `ctrl_val`, clear `checksum`, `error` and offset.
  - If `length`==0 or >CROM_SIZE: set `error`, stay IDLE, issue no bus cycle.
  - Otherwise set `busy` and go to CLR.
- CLR: control write, adr 0, data 0x00. This disables mm/mbx/banked so the CPU cannot write the array during load. On ack, go to FETCH.
- FETCH: `s_ready`=1. On `s_valid`, latch byte, add it to `checksum`, go to WRITE.
- WRITE: array write, adr = {1,00000,offset}, data = latched byte. On ack, offset+1.
  - If offset+1 == length, go to CTRL.
  - Otherwise go to FETCH.
- CTRL: control write, adr 0, data = `ctrl_val`. On ack, go to IDLE, clear `busy`, pulse `done`.
- Offset is 15 bits and never exceeds `length`-1; no wrap.
- Abort:
  - In FETCH: go to IDLE on the next edge and set `error`. The byte is not consumed, even if `s_valid` is high that cycle.
  - In CLR/WRITE/CTRL: the current bus cycle runs to ack or timeout, then go to IDLE and set `error`.
  - No `done` pulse after abort.
- Timeout: a counter runs while `wb_stb_o`=1 and `wb_ack_i`=0. When it reaches TIMEOUT, drop cyc/stb, set `error`, clear `busy`, go to IDLE. No `done` pulse.
- Reset: all outputs 0 and state IDLE on the next edge, including mid-cycle (cyc/stb drop).

## Timing
- All outputs are registered.
- `wb_cyc_o`/`wb_stb_o` rise on the edge that enters CLR, WRITE or CTRL. They clear on the edge where `wb_ack_i`=1 is sampled.
- The slave acks one cycle after strobe. The master must drop stb the same edge, so the slave never sees a second ack.
- A strobe may wait arbitrarily for ack: the slave withholds ack on CPU collision. adr/dat stay stable throughout.
- Per byte: FETCH→WRITE one edge when `s_valid` is already high; WRITE lasts ≥2 cycles. Minimum 3 cycles per byte.
- `s_ready` is high only in FETCH. Byte transfer happens when `s_ready`&&`s_valid`.
- `done` is high exactly the cycle after CTRL ack, together with `busy`=0.
- `start` coincident with `abort` in IDLE: `start` wins; `abort` is ignored in IDLE.
- Ack coincident with `abort`: the write counts as completed (offset and checksum stand), then go to IDLE.

## Test plan
- length=3, bytes 0x11,0x22,0x33, ctrl_val=0x23, immediate ack model → writes ctrl 0x00, array[0..2]=0x11/0x22/0x33, ctrl 0x23; `done` pulse; checksum=0x66; error=0.
- length=0 and length=17410 → `error`=1, no cyc; a following legal start clears `error`.
- Slave holds ack low 10 cycles on byte 1 → adr/dat stable, a single write per byte, final array correct.
- No ack for 255 cycles in CLR → cyc drops, `error`=1, `busy`=0, no `done`.
- `abort` during FETCH after 2 of 5 bytes, and again during a WRITE awaiting ack → write completes, IDLE, `error`=1, checksum reflects completed bytes only.
- `reset` asserted mid-WRITE with stb high → next edge cyc/stb/busy/s_ready=0; a new start performs a clean full load.
